// File: rtl/evolution_sweeper.sv
// evolution_sweeper: row-sweep sequencer feeding a combinational Game-of-Life block core
module evolution_sweeper #(
  parameter int GRID_W = 100,
  parameter int GRID_H = 100,
  parameter int BLOCK_LEN = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        rd_en,
  output logic [$clog2(GRID_H)-1:0]   rd_addr,
  input  logic [GRID_W-1:0]           rd_data,
  output logic                        wr_en,
  output logic [$clog2(GRID_H)-1:0]   wr_addr,
  output logic [GRID_W-1:0]           wr_data,
  output logic [3*BLOCK_LEN-1:0]      ev_line_status,
  output logic [5:0]                  ev_last_block_tail,
  input  logic [BLOCK_LEN-1:0]        ev_now_live,
  input  logic                        ev_prev_live
);
  localparam int NB = GRID_W / BLOCK_LEN;
  localparam int AW = $clog2(GRID_H);
  localparam int BW = $clog2(NB + 1);
  typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, SWEEP, WRITE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [GRID_W-1:0] prev, cur, nxt, acc, nxt_eff, nmask, nval, pmask;
  logic [GRID_W:0] pone;
  logic [AW-1:0] r;
  logic [AW:0] r2;
  logic [BW-1:0] b;
  logic [5:0] tail;
  logic fresh, last, more, flush;
  logic [31:0] sh;
  logic [3*BLOCK_LEN-1:0] win;
  assign r2 = {1'b0, r} + (AW+1)'(2);
  assign last = r == AW'(GRID_H - 1);
  assign more = r2 < (AW+1)'(GRID_H);
  assign flush = b == BW'(NB);
  assign sh = 32'(b) * 32'(BLOCK_LEN);
  // Row 1 only lands on the RAM port during the first sweep cycle, so it is used straight from there once.
  assign nxt_eff = fresh ? rd_data : nxt;
  assign win = {BLOCK_LEN'(nxt_eff >> sh), BLOCK_LEN'(cur >> sh), BLOCK_LEN'(prev >> sh)};
  assign nmask = GRID_W'({(BLOCK_LEN-1){1'b1}}) << sh;
  assign nval = GRID_W'(ev_now_live) << sh;
  assign pone = (GRID_W+1)'(1) << sh;
  assign pmask = GRID_W'(pone >> 1);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = state == DONE;
    rd_en = 1'b0;
    rd_addr = '0;
    wr_en = state == WRITE;
    wr_addr = wr_en ? r : '0;
    wr_data = wr_en ? acc : '0;
    ev_line_status = state == SWEEP ? win : '0;
    ev_last_block_tail = state == SWEEP ? tail : '0;
    case (state)
      IDLE: state_n = start ? PRIME0 : IDLE;
      PRIME0: begin
        rd_en = 1'b1;
        state_n = PRIME1;
      end
      PRIME1: begin
        rd_en = 1'b1;
        rd_addr = AW'(1);
        state_n = SWEEP;
      end
      SWEEP: state_n = flush ? WRITE : SWEEP;
      WRITE: begin
        rd_en = more;
        rd_addr = more ? AW'(r2) : '0;
        state_n = last ? DONE : SHIFT;
      end
      SHIFT: state_n = SWEEP;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cur <= '0;
      nxt <= '0;
      acc <= '0;
      r <= '0;
      b <= '0;
      tail <= '0;
      fresh <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r <= '0;
          prev <= '0;
          acc <= '0;
        end
        PRIME1: begin
          cur <= rd_data;
          fresh <= 1'b1;
          b <= '0;
          tail <= '0;
        end
        SWEEP: begin
          acc <= (acc & ~(nmask | pmask)) | (nval & nmask) | (ev_prev_live ? pmask : '0);
          fresh <= 1'b0;
          if (fresh) nxt <= rd_data;
          if (!flush) begin
            b <= b + BW'(1);
            tail <= {win[3*BLOCK_LEN-1], win[2*BLOCK_LEN-1], win[BLOCK_LEN-1],
                     win[3*BLOCK_LEN-2], win[2*BLOCK_LEN-2], win[BLOCK_LEN-2]};
          end
        end
        SHIFT: begin
          prev <= cur;
          cur <= nxt;
          nxt <= more ? rd_data : '0;
          r <= r + AW'(1);
          b <= '0;
          tail <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
